// File: rtl/score_ctl.sv
// score_ctl: rally sequencer and score keeper for the pong game.
// Watches ball_ctl's x position for goals, keeps both scores, and holds the
// ball at centre (ball_rst) whenever play is not live.
module score_ctl #(
  parameter int LEFT_LIMIT  = 16,
  parameter int RIGHT_LIMIT = 1007,
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_DELAY = 65_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] xpos,
  output logic        ball_rst,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        serve_dir,
  output logic        point_pulse,
  output logic [1:0]  winner,
  output logic [2:0]  state
);

  localparam int CW = $clog2(SERVE_DELAY + 1);

  localparam logic [10:0]   LEFT_L     = 11'(LEFT_LIMIT);
  localparam logic [10:0]   RIGHT_L    = 11'(RIGHT_LIMIT);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    score_l_d, score_r_d;
  logic [1:0]    winner_d;
  logic          serve_dir_d;
  logic          start_q;
  logic          start_rise;

  // A start level held over from the last game must not restart play.
  assign start_rise = start & ~start_q;
  assign state      = state_q;

  // Next-state and next-register logic for the rally sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = '0;
    score_l_d   = score_l;
    score_r_d   = score_r;
    winner_d    = winner;
    serve_dir_d = serve_dir;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SERVE;
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = 2'b00;
        end
      end
      SERVE: begin
        if (cnt_q == SERVE_LAST) begin
          state_d = PLAY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PLAY: begin
        // Left goal checked first; the limits never overlap in practice.
        if (xpos <= LEFT_L) begin
          score_r_d   = score_r + 4'd1;
          serve_dir_d = 1'b0;
          state_d     = POINT;
        end else if (xpos >= RIGHT_L) begin
          score_l_d   = score_l + 4'd1;
          serve_dir_d = 1'b1;
          state_d     = POINT;
        end
      end
      POINT: begin
        if (score_l == WIN) begin
          winner_d = 2'b01;
          state_d  = OVER;
        end else if (score_r == WIN) begin
          winner_d = 2'b10;
          state_d  = OVER;
        end else begin
          state_d = SERVE;
        end
      end
      OVER: begin
        if (start_rise) begin
          state_d   = SERVE;
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      score_l     <= '0;
      score_r     <= '0;
      winner      <= 2'b00;
      serve_dir   <= 1'b1;
      ball_rst    <= 1'b1;
      point_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_q     <= start;
      score_l     <= score_l_d;
      score_r     <= score_r_d;
      winner      <= winner_d;
      serve_dir   <= serve_dir_d;
      ball_rst    <= (state_d != PLAY);
      point_pulse <= (state_d == POINT);
    end
  end

endmodule

// File: tb/tb_score_ctl.sv
// Directed testbench for score_ctl with SERVE_DELAY=4 and WIN_SCORE=3.
module tb_score_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] xpos;
  logic        ball_rst;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic        serve_dir;
  logic        point_pulse;
  logic [1:0]  winner;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  score_ctl #(
    .LEFT_LIMIT (16),
    .RIGHT_LIMIT(1007),
    .WIN_SCORE  (3),
    .SERVE_DELAY(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .xpos       (xpos),
    .ball_rst   (ball_rst),
    .score_l    (score_l),
    .score_r    (score_r),
    .serve_dir  (serve_dir),
    .point_pulse(point_pulse),
    .winner     (winner),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; outputs are read 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From SERVE just entered: 3 more cycles in SERVE, then PLAY with ball released.
  task automatic serve_to_play(input string tag);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (state !== 3'd1) begin
        errors++;
        $display("FAIL %s serve_hold%0d: state=%0d expected 1", tag, i, state);
      end
    end
    step();
    checks++;
    if (state !== 3'd2 || ball_rst !== 1'b0) begin
      errors++;
      $display("FAIL %s serve_end: state=%0d ball_rst=%b expected 2/0", tag, state, ball_rst);
    end
  endtask

  // From PLAY: drive a goal position for one edge and check the POINT cycle.
  task automatic goal(input logic [10:0] x, input logic [3:0] exp_l, input logic [3:0] exp_r,
                      input logic exp_dir, input string tag);
    xpos = x;
    step();
    xpos = 11'd512;
    checks++;
    if (state !== 3'd3 || point_pulse !== 1'b1 || ball_rst !== 1'b1 ||
        score_l !== exp_l || score_r !== exp_r || serve_dir !== exp_dir) begin
      errors++;
      $display("FAIL %s point: state=%0d pulse=%b ball_rst=%b l=%0d r=%0d dir=%b expected 3/1/1 l=%0d r=%0d dir=%b",
               tag, state, point_pulse, ball_rst, score_l, score_r, serve_dir, exp_l, exp_r, exp_dir);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; xpos = 11'd512;
    step(); step();
    checks++;
    if (state !== 3'd0 || ball_rst !== 1'b1 || score_l !== 4'd0 || score_r !== 4'd0 ||
        winner !== 2'b00 || serve_dir !== 1'b1 || point_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: state=%0d ball_rst=%b l=%0d r=%0d win=%b dir=%b pulse=%b expected 0/1/0/0/00/1/0",
               state, ball_rst, score_l, score_r, winner, serve_dir, point_pulse);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (state !== 3'd0 || ball_rst !== 1'b1) begin
        errors++;
        $display("FAIL idle_hold%0d: state=%0d ball_rst=%b expected 0/1", i, state, ball_rst);
      end
    end
  endtask

  task automatic test_serve();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (state !== 3'd1 || ball_rst !== 1'b1) begin
      errors++;
      $display("FAIL serve_enter: state=%0d ball_rst=%b expected 1/1", state, ball_rst);
    end
    serve_to_play("serve");
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (state !== 3'd2 || point_pulse !== 1'b0) begin
        errors++;
        $display("FAIL centre_play%0d: state=%0d pulse=%b expected 2/0", i, state, point_pulse);
      end
    end
  endtask

  task automatic test_left_goal();
    goal(11'd16, 4'd0, 4'd1, 1'b0, "left");
    step();
    checks++;
    if (state !== 3'd1 || point_pulse !== 1'b0) begin
      errors++;
      $display("FAIL left_after: state=%0d pulse=%b expected 1/0", state, point_pulse);
    end
    serve_to_play("left");
    xpos = 11'd17;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (state !== 3'd2 || score_r !== 4'd1) begin
        errors++;
        $display("FAIL left_boundary%0d: state=%0d r=%0d expected 2/1", i, state, score_r);
      end
    end
  endtask

  task automatic test_right_goal();
    goal(11'd1007, 4'd1, 4'd1, 1'b1, "right");
    step();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL right_after: state=%0d expected 1", state);
    end
    serve_to_play("right");
    xpos = 11'd1006;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (state !== 3'd2 || score_l !== 4'd1) begin
        errors++;
        $display("FAIL right_boundary%0d: state=%0d l=%0d expected 2/1", i, state, score_l);
      end
    end
    xpos = 11'd512;
  endtask

  task automatic test_game_over();
    rst = 1'b0;
    step();
    rst = 1'b1;
    start = 1'b1;
    step();
    serve_to_play("over_s0");
    goal(11'd16, 4'd0, 4'd1, 1'b0, "over_g1");
    step();
    serve_to_play("over_s1");
    goal(11'd10, 4'd0, 4'd2, 1'b0, "over_g2");
    step();
    serve_to_play("over_s2");
    goal(11'd0, 4'd0, 4'd3, 1'b0, "over_g3");
    step();
    checks++;
    if (state !== 3'd4 || winner !== 2'b10 || score_r !== 4'd3 || point_pulse !== 1'b0) begin
      errors++;
      $display("FAIL over_enter: state=%0d win=%b r=%0d pulse=%b expected 4/10/3/0",
               state, winner, score_r, point_pulse);
    end
    xpos = 11'd1010;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (state !== 3'd4 || score_l !== 4'd0 || score_r !== 4'd3 || ball_rst !== 1'b1) begin
        errors++;
        $display("FAIL over_hold%0d: state=%0d l=%0d r=%0d ball_rst=%b expected 4/0/3/1",
                 i, state, score_l, score_r, ball_rst);
      end
    end
    xpos = 11'd512;
    start = 1'b0;
    step();
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL over_drop: state=%0d expected 4", state);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (state !== 3'd1 || score_l !== 4'd0 || score_r !== 4'd0 || winner !== 2'b00) begin
      errors++;
      $display("FAIL over_restart: state=%0d l=%0d r=%0d win=%b expected 1/0/0/00",
               state, score_l, score_r, winner);
    end
  endtask

  task automatic test_reset_mid_play();
    serve_to_play("mid_s0");
    goal(11'd1007, 4'd1, 4'd0, 1'b1, "mid_g1");
    step();
    serve_to_play("mid_s1");
    goal(11'd1020, 4'd2, 4'd0, 1'b1, "mid_g2");
    step();
    serve_to_play("mid_s2");
    rst = 1'b0;
    step();
    checks++;
    if (state !== 3'd0 || score_l !== 4'd0 || score_r !== 4'd0 || ball_rst !== 1'b1 ||
        winner !== 2'b00 || point_pulse !== 1'b0 || serve_dir !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: state=%0d l=%0d r=%0d ball_rst=%b win=%b pulse=%b dir=%b expected 0/0/0/1/00/0/1",
               state, score_l, score_r, ball_rst, winner, point_pulse, serve_dir);
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_serve();
    test_left_goal();
    test_right_goal();
    test_game_over();
    test_reset_mid_play();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/score_ctl.md
# score_ctl

Game-flow and scoring controller that sits directly downstream of `ball_ctl`. It watches the ball's horizontal position and detects a goal at either screen edge. It keeps both players' scores and sequences the rally through idle, serve, play, point and game-over phases. It drives the ball controller's reset so that the ball re-centres before every serve.

## Interface
Parameters:
- `LEFT_LIMIT`, 16: a left goal is detected when `xpos <= LEFT_LIMIT`.
- `RIGHT_LIMIT`, 1007: a right goal is detected when `xpos >= RIGHT_LIMIT`. Must be greater than `LEFT_LIMIT`.
- `WIN_SCORE`, 5: points needed to win. Range 1..15.
- `SERVE_DELAY`, 65_000_000: number of cycles the ball is held centred before play starts (1 s at 65 MHz).

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: level input, sampled each cycle; starts or restarts a game.
- `xpos` in 11: ball x position from `ball_ctl`.
- `ball_rst` out 1: connects to `ball_ctl` `rst`. High means the ball is held at centre.
- `score_l` out 4: left player's score.
- `score_r` out 4: right player's score.
- `serve_dir` out 1: direction of the next serve. 1 = toward the right player, 0 = toward the left player.
- `point_pulse` out 1: one-cycle strobe when a point is scored.
- `winner` out 2: 00 = none, 01 = left player won, 10 = right player won.
- `state` out 3: current FSM state, exported for debug and the HUD.

## Operation
FSM states and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4. All outputs are registered.

- **IDLE**
  - `ball_rst`=1.
  - If `start`=1, go to SERVE, clear both scores, clear `winner`, and load the serve counter with 0.
- **SERVE**
  - `ball_rst`=1.
  - The counter increments every cycle.
  - When the counter reaches `SERVE_DELAY-1`, go to PLAY.
  - `start` is ignored.
- **PLAY**
  - `ball_rst`=0.
  - If `xpos <= LEFT_LIMIT`: `score_r` increments, `serve_dir` is set to 0, go to POINT.
  - Else if `xpos >= RIGHT_LIMIT`: `score_l` increments, `serve_dir` is set to 1, go to POINT.
  - Because the limits are disjoint, both goals cannot occur together. The left check has priority as a safeguard.
  - `start` is ignored.
- **POINT** (lasts exactly 1 cycle)
  - `ball_rst`=1 and `point_pulse`=1.
  - If `score_l == WIN_SCORE`: `winner`=01, go to OVER.
  - Else if `score_r == WIN_SCORE`: `winner`=10, go to OVER.
  - Otherwise, clear the serve counter and go to SERVE.
- **OVER**
  - `ball_rst`=1 and scores are frozen.
  - A rising edge of `start` (detected against a registered copy) clears the scores and `winner` and goes to SERVE.
  - A rising edge is required so that a `start` level still held from the previous game does not immediately restart play.
- **Score arithmetic**
  - Scores are 4-bit and increment only in PLAY.
  - They can never exceed `WIN_SCORE`, because OVER is entered as soon as `WIN_SCORE` is reached. There is no wrap-around.
- **Serve counter**
  - Width is `$clog2(SERVE_DELAY+1)`.
  - Held at 0 outside SERVE.

## Timing
- **Reset** (`rst`=0 at a clock edge):
  - State = IDLE; `ball_rst`=1.
  - `score_l`=`score_r`=0; `winner`=00; `point_pulse`=0.
  - `serve_dir`=1; serve counter = 0; `start` edge register = 0.
- **Reset mid-game**: any state returns to IDLE on the next edge, with all outputs at their reset values.
- **`start` in IDLE**: `start` high at edge N puts state=SERVE after edge N.
- **SERVE length**: state=PLAY exactly `SERVE_DELAY` cycles after SERVE is entered, and `ball_rst` falls in the same cycle. `ball_ctl` therefore leaves centre one cycle later.
- **Goal latency**: a goal-condition `xpos` sampled at edge N gives state=POINT, the updated score and `point_pulse`=1 after edge N. After edge N+1, the state is SERVE or OVER and `point_pulse`=0.
- **`xpos` in SERVE**: `xpos` at centre during SERVE is never evaluated, so no false goal occurs at the moment play is released.

## Test plan
Bench parameters: `SERVE_DELAY`=4, `WIN_SCORE`=3, default limits.

1. **Reset values.** Hold `rst`=0 for 2 cycles -> state=0, `ball_rst`=1, both scores 0, `winner`=00, `serve_dir`=1. Then release `rst` with `start`=0 for 10 cycles -> state stays 0.
2. **Start and serve.** Pulse `start` -> state=1 for exactly 4 cycles, then state=2 with `ball_rst`=0. With `xpos`=512 for 50 cycles -> no state change.
3. **Left goal.** In PLAY, drive `xpos`=16 -> next cycle `score_r`=1, `point_pulse`=1 for one cycle, `serve_dir`=0, then state=1. Drive `xpos`=17 instead -> no goal.
4. **Right goal.** In PLAY, drive `xpos`=1007 -> `score_l`=1, `serve_dir`=1. Drive `xpos`=1006 -> no goal.
5. **Game over.** Let the right player score three times -> after the third POINT, state=4, `winner`=10, `score_r`=3. With `start` held high throughout, stay in OVER. Drop `start` and raise it again -> SERVE, scores 0, `winner`=00.
6. **Reset mid-play.** Assert `rst`=0 during PLAY with `score_l`=2 -> after the next edge, IDLE with both scores 0 and `ball_rst`=1.
